// File: rtl/_shift_reg_r_4bits.sv
// ---------------------------------------------------------------------------
// _shift_reg_r_4bits : 4-bit right-shift register with serial input.
//   clk_i : rising-edge clock
//   rst_i : asynchronous active-high reset, clears the register to 0
//   en_i  : shift enable
//   sin_i : serial input, enters at the MSB
//   q_o   : register contents; after 4 shifts the first bit is in q_o[0]
// ---------------------------------------------------------------------------
module _shift_reg_r_4bits (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       sin_i,
    output logic [3:0] q_o
);

    logic [3:0] sr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q <= 4'h0;
        end else if (en_i) begin
            sr_q <= {sin_i, sr_q[3:1]};
        end
    end

    assign q_o = sr_q;

endmodule

// File: rtl/_xor2.sv
// ---------------------------------------------------------------------------
// _xor2 : two-input XOR gate cell.
//   a_i, b_i : gate inputs
//   y_o      : a_i ^ b_i
// ---------------------------------------------------------------------------
module _xor2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    assign y_o = a_i ^ b_i;

endmodule

// File: rtl/_ser_rx_4bits.sv
// ---------------------------------------------------------------------------
// _ser_rx_4bits : serial frame receiver (start, d0..d3 LSB first, parity,
// stop), one bit per clock.
//   clk     : rising-edge clock, one bit period per cycle
//   reset   : asynchronous active-high reset
//   s_in    : serial line, idles high
//   data    : last accepted word, held until the next accepted frame
//   valid   : 1-cycle pulse, frame accepted and data updated
//   par_err : 1-cycle pulse, parity mismatch with a good stop bit
//   frm_err : 1-cycle pulse, stop bit sampled as 0
//   busy    : high in every state except IDLE
// Output pulses appear in the cycle after the edge that samples the stop bit;
// at most one of them is high in any cycle.
// ---------------------------------------------------------------------------
module _ser_rx_4bits #(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_in,
    output logic [3:0] data,
    output logic       valid,
    output logic       par_err,
    output logic       frm_err,
    output logic       busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] DATA    = 3'd1;
    localparam logic [2:0] PARITY  = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] WAIT_HI = 3'd4;

    localparam int         DATA_BITS = 4;
    localparam logic [1:0] LAST_BIT  = 2'(DATA_BITS - 1);

    logic [2:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       par_q, par_d;
    logic [3:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;

    logic [3:0] sr;
    logic       shift_en;

    assign shift_en = (state_q == DATA);

    _shift_reg_r_4bits u_sr (
        .clk_i (clk),
        .rst_i (reset),
        .en_i  (shift_en),
        .sin_i (s_in),
        .q_o   (sr)
    );

    // Parity tree: XOR of the four data bits, the received parity bit and
    // the configured polarity; a 1 at the root means mismatch.
    logic x01, x23, x_data, x_par, par_bad;

    _xor2 u_x01  (.a_i(sr[0]),  .b_i(sr[1]),      .y_o(x01));
    _xor2 u_x23  (.a_i(sr[2]),  .b_i(sr[3]),      .y_o(x23));
    _xor2 u_xd   (.a_i(x01),    .b_i(x23),        .y_o(x_data));
    _xor2 u_xp   (.a_i(x_data), .b_i(par_q),      .y_o(x_par));
    _xor2 u_xodd (.a_i(x_par),  .b_i(PARITY_ODD), .y_o(par_bad));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!s_in) begin
                    state_d = DATA;
                    cnt_d   = 2'd0;
                end
            end
            DATA: begin
                // The shift register samples s_in on this same edge.
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_BIT) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                par_d   = s_in;
                state_d = STOP;
            end
            STOP: begin
                if (!s_in) begin
                    // Framing error wins over any parity result.
                    ferr_d  = 1'b1;
                    state_d = WAIT_HI;
                end else if (par_bad) begin
                    perr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    data_d  = sr;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_HI: begin
                // Sit out a line break; only a high line rearms start detect.
                if (s_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            par_q   <= 1'b0;
            data_q  <= 4'h0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign par_err = perr_q;
    assign frm_err = ferr_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb__ser_rx_4bits.sv
// Bench for _ser_rx_4bits. Inputs change on the falling edge; outputs are
// sampled on the falling edge or 1 time unit after the rising edge.
// Event encoding in the scoreboard: {kind[1:0], data[3:0]},
// kind 1 = valid, 2 = par_err, 3 = frm_err.
module tb__ser_rx_4bits;

  localparam bit PARITY_ODD = 1'b0;

  logic       clk;
  logic       reset;
  logic       s_in;
  logic [3:0] data;
  logic       valid;
  logic       par_err;
  logic       frm_err;
  logic       busy;

  _ser_rx_4bits #(.PARITY_ODD(PARITY_ODD)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_in    (s_in),
    .data    (data),
    .valid   (valid),
    .par_err (par_err),
    .frm_err (frm_err),
    .busy    (busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [5:0] exp_q[$];
  int         exp_cyc_q[$];
  int         cyc = 0;
  logic [3:0] last_data = 4'h0;

  always @(posedge clk) begin
    logic [5:0] ev;
    logic [1:0] kind;
    int         ecyc;
    cyc++;
    #1;
    if (!reset && (valid || par_err || frm_err)) begin
      chk_eq("onehot", 32'(valid) + 32'(par_err) + 32'(frm_err), 32'd1);
      kind = valid ? 2'd1 : (par_err ? 2'd2 : 2'd3);
      chk_eq("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        ev   = exp_q.pop_front();
        ecyc = exp_cyc_q.pop_front();
        chk_eq("event", {26'd0, kind, data}, {26'd0, ev});
        chk_eq("latency", 32'(cyc), 32'(ecyc));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_bit(input logic b, input logic chk_busy);
    @(negedge clk);
    if (chk_busy) chk_eq("busy_mid", 32'(busy), 32'd1);
    s_in = b;
  endtask

  task automatic send_frame(input logic [3:0] d, input logic par_flip, input logic stop);
    logic par;
    par = (^d) ^ PARITY_ODD ^ par_flip;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i], 1'b1);
    send_bit(par, 1'b1);
    // Stop bit: model the outcome before it is sampled.
    @(negedge clk);
    chk_eq("busy_mid", 32'(busy), 32'd1);
    if (!stop) begin
      exp_q.push_back({2'd3, last_data});
    end else if (par_flip) begin
      exp_q.push_back({2'd2, last_data});
    end else begin
      exp_q.push_back({2'd1, d});
      last_data = d;
    end
    exp_cyc_q.push_back(cyc + 1);
    s_in = stop;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_eq("idle_busy", 32'(busy), 32'd0);
      chk_eq("idle_data", 32'(data), 32'(last_data));
      s_in = 1'b1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    s_in  = 1'b1;
    #1;
    chk_eq("reset_outs", {27'd0, busy, valid, par_err, frm_err, 1'b0}, 32'd0);
    chk_eq("reset_data", 32'(data), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle line.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_eq("idle_outs", {28'd0, busy, valid, par_err, frm_err}, 32'd0);
      chk_eq("idle_data", 32'(data), 32'd0);
    end

    // Good frame 0xB.
    send_frame(4'hB, 1'b0, 1'b1);
    idle_check(3);

    // Same frame, parity flipped.
    send_frame(4'hB, 1'b1, 1'b1);
    idle_check(3);

    // Framing error followed by a line break.
    send_frame(4'h5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_eq("break_busy", 32'(busy), 32'd1);
      s_in = 1'b0;
    end
    @(negedge clk);
    chk_eq("break_busy", 32'(busy), 32'd1);
    s_in = 1'b1;
    idle_check(3);

    // Back-to-back frames.
    send_frame(4'h3, 1'b0, 1'b1);
    send_frame(4'hC, 1'b0, 1'b1);
    idle_check(3);

    // Random frames, mixed outcomes, random gaps.
    for (int n = 0; n < 20; n++) begin
      logic [3:0] d;
      logic       pf;
      d  = 4'($urandom_range(0, 15));
      pf = ($urandom_range(0, 3) == 0);
      send_frame(d, pf, 1'b1);
      if ($urandom_range(0, 1) == 1) idle_check($urandom_range(1, 3));
    end
    idle_check(2);

    // Reset in the middle of frame 0xF, after d1.
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_eq("midrst_outs", {28'd0, busy, valid, par_err, frm_err}, 32'd0);
    chk_eq("midrst_data", 32'(data), 32'd0);
    last_data = 4'h0;
    @(negedge clk);
    reset = 1'b0;
    s_in  = 1'b1;
    idle_check(2);
    send_frame(4'h6, 1'b0, 1'b1);
    idle_check(4);

    chk_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
